// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Branch prediction bookkeeping and resolution.
//            - IF side: selects the predicted next PC from the predictor bit.
//            - Carries a per-instruction prediction record alongside the
//              IF/ID and ID/EXE pipeline registers (ID slot, EXE slot).
//            - EXE side: compares the recorded prediction with the actual
//              outcome and issues a flush plus corrected PC on a mispredict.
//              When the pipeline is stalled at that moment, the corrected PC
//              is latched and the redirect is issued on the first
//              un-stalled cycle (RUN/PEND state machine).
// Options  : PREDICT_STATS_EN - when defined, branch_cnt counts resolved
//            branches and miss_cnt counts flushes (both wrap at 2^32).
//            When undefined both outputs are tied to 0 and no counter
//            registers are built.
// Ports    :
//   clk          in   1   system clock
//   rst          in   1   asynchronous active-high reset
//   pc_IF        in  32   fetch PC
//   is_branch_IF in   1   fetched instruction is a conditional branch
//   target_IF    in  32   branch target decoded in IF
//   taken_sel    in   1   predictor output (1 = predict taken)
//   opcode_EXE   in   7   EXE-stage opcode
//   jump_sel     in   1   actual branch outcome in EXE
//   jtarget_EXE  in  32   actual branch target in EXE
//   Istall       in   1   instruction-side stall
//   Dstall       in   1   data-side stall
//   pc_sel_IF    out  1   select predicted target for next PC
//   pred_pc_IF   out 32   predicted next PC
//   flush        out  1   kill IF/ID and ID/EXE
//   redirect_pc  out 32   corrected PC (0 when no redirect)
//   mispredict   out  1   EXE mispredict detected
//   branch_cnt   out 32   resolved-branch counter (0 without stats)
//   miss_cnt     out 32   flush counter (0 without stats)
// Revision : 1.0 - initial release
// ============================================================================

module branch_resolve (
    input  logic        clk,
    input  logic        rst,
    // IF stage
    input  logic [31:0] pc_IF,
    input  logic        is_branch_IF,
    input  logic [31:0] target_IF,
    input  logic        taken_sel,
    // EXE stage
    input  logic [6:0]  opcode_EXE,
    input  logic        jump_sel,
    input  logic [31:0] jtarget_EXE,
    input  logic        Istall,
    input  logic        Dstall,
    // Outputs
    output logic        pc_sel_IF,
    output logic [31:0] pred_pc_IF,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    // Conditional-branch opcode (RV32I BRANCH major opcode)
    localparam logic [6:0] C_BTYPE = 7'b1100011;

    // ------------------------------------------------------------------
    // Prediction record carried down the pipe with each instruction
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        valid;
        logic        pred_taken;
        logic [31:0] pc_plus4;
        logic [31:0] pred_target;
    } rec_t;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    rec_t        id_q,  id_d;
    rec_t        exe_q, exe_d;
    state_t      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        w_stall;
    logic [31:0] w_pc_plus4_IF;
    logic        w_exe_branch;
    logic        w_cmp_miss;
    logic [31:0] w_corr_pc;

    assign w_stall       = Istall | Dstall;
    assign w_pc_plus4_IF = pc_IF + 32'd4;

    // ------------------------------------------------------------------
    // IF-side prediction (purely combinational)
    // ------------------------------------------------------------------
    assign pc_sel_IF  = is_branch_IF & taken_sel;
    assign pred_pc_IF = pc_sel_IF ? target_IF : w_pc_plus4_IF;

    // ------------------------------------------------------------------
    // EXE-side compare
    // A not-taken prediction that turns out not taken is correct no matter
    // what target was decoded, so the target only matters when taken.
    // ------------------------------------------------------------------
    assign w_exe_branch = exe_q.valid & (opcode_EXE == C_BTYPE);
    assign w_cmp_miss   = w_exe_branch &
                          ((exe_q.pred_taken != jump_sel) |
                           (jump_sel & (exe_q.pred_target != jtarget_EXE)));
    assign w_corr_pc    = jump_sel ? jtarget_EXE : exe_q.pc_plus4;

    // ------------------------------------------------------------------
    // Redirect FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        flush       = 1'b0;
        redirect_pc = 32'd0;
        mispredict  = 1'b0;

        case (state_q)
            S_RUN: begin
                mispredict = w_cmp_miss;
                if (w_cmp_miss) begin
                    if (!w_stall) begin
                        flush       = 1'b1;
                        redirect_pc = w_corr_pc;
                    end else begin
                        // The pipe is frozen; remember where to go and
                        // issue the redirect once it moves again.
                        pend_pc_d = w_corr_pc;
                        state_d   = S_PEND;
                    end
                end
            end

            S_PEND: begin
                // The EXE slot still holds the branch already resolved, so
                // its compare result is deliberately not looked at here.
                if (!w_stall) begin
                    flush       = 1'b1;
                    redirect_pc = pend_pc_q;
                    state_d     = S_RUN;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Record pipe next state
    // Flush wins over the IF load: whatever IF presents that cycle is on
    // the wrong path and is dropped together with the ID/EXE contents.
    // ------------------------------------------------------------------
    always_comb begin
        id_d  = id_q;
        exe_d = exe_q;

        if (!w_stall) begin
            if (flush) begin
                id_d.valid  = 1'b0;
                exe_d.valid = 1'b0;
            end else begin
                id_d.valid       = is_branch_IF;
                id_d.pred_taken  = pc_sel_IF;
                id_d.pc_plus4    = w_pc_plus4_IF;
                id_d.pred_target = target_IF;
                exe_d            = id_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= '0;
            exe_q     <= '0;
            state_q   <= S_RUN;
            pend_pc_q <= 32'd0;
        end else begin
            id_q      <= id_d;
            exe_q     <= exe_d;
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional prediction statistics
    // ------------------------------------------------------------------
`ifdef PREDICT_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] miss_cnt_q,   miss_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        // A stalled EXE branch is counted once, on the cycle it finally
        // moves, so a long stall does not inflate the count.
        if (w_exe_branch && !w_stall) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (flush) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;
`else
    assign branch_cnt = 32'd0;
    assign miss_cnt   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-002 SHALL have inputs: pc_IF 32 fetch PC; is_branch_IF 1 fetched instruction is `Btype; target_IF 32 branch target decoded in IF; taken_sel 1 predictor output.
REQ-003 SHALL have inputs: opcode_EXE 7 EXE-stage opcode; jump_sel 1 actual branch outcome in EXE; jtarget_EXE 32 actual branch target; Istall 1; Dstall 1.
REQ-004 SHALL have outputs: pc_sel_IF 1 select predicted target for next PC; pred_pc_IF 32 predicted next PC; flush 1 kill IF/ID and ID/EXE; redirect_pc 32 corrected PC; mispredict 1 EXE mispredict detected.
REQ-005 SHALL have outputs branch_cnt 32 and miss_cnt 32 (see Configuration).

Function
REQ-006 SHALL drive pc_sel_IF = is_branch_IF & taken_sel, combinationally.
REQ-007 SHALL drive pred_pc_IF = target_IF when pc_sel_IF, else pc_IF + 4 (32-bit wrap).
REQ-008 SHALL keep a 2-stage record pipe (ID slot, EXE slot), each {valid, pred_taken, pc_plus4, pred_target}, mirroring IF/ID and ID/EXE.
REQ-009 SHALL, when stall = Istall|Dstall is 0 and flush is 0: load the ID slot from IF (valid = is_branch_IF) and move the ID slot into the EXE slot.
REQ-010 SHALL hold both slots unchanged while stall = 1.
REQ-011 SHALL, on flush = 1 with stall = 0, clear valid in both slots at the clock edge.
REQ-012 SHALL compute mispredict = EXE valid & opcode_EXE == `Btype & (pred_taken != jump_sel | (jump_sel & pred_target != jtarget_EXE)), combinationally.
REQ-013 SHALL compute corrected PC = jtarget_EXE if jump_sel, else EXE pc_plus4.
REQ-014 SHALL implement FSM RUN / PEND, reset to RUN.
REQ-015 RUN: mispredict & !stall -> flush = 1, redirect_pc = corrected PC the same cycle, stay RUN.
REQ-016 RUN: mispredict & stall -> latch corrected PC, go to PEND, flush = 0.
REQ-017 PEND: flush = 1 only in the first cycle with stall = 0, redirect_pc = latched PC; then go to RUN; EXE-slot compare SHALL be ignored while in PEND.
REQ-018 SHALL drive flush = 0 and redirect_pc = 0 whenever no redirect is issued.
REQ-019 SHALL not raise mispredict for a non-`Btype EXE opcode even if EXE valid = 1.
REQ-020 SHALL give flush priority over an IF load in the same cycle; the IF record is discarded.

Reset
REQ-021 On rst: both slots invalid, all fields 0, FSM = RUN, latched PC = 0, counters = 0.
REQ-022 SHALL hold flush = 0, mispredict = 0, redirect_pc = 0 from reset until the first resolved branch; pc_sel_IF and pred_pc_IF stay combinational.
REQ-023 Reset asserted mid-PEND SHALL abandon the pending redirect; no flush after release.

Configuration
REQ-024 Macro PREDICT_STATS_EN: when defined, branch_cnt increments on each EXE-valid `Btype resolved with !stall; miss_cnt increments on each flush; both wrap at 2^32.
REQ-025 Without PREDICT_STATS_EN, branch_cnt and miss_cnt SHALL be constant 0 and no counter registers exist.

Verification
REQ-026 Branch at pc 0x100, target 0x140, taken_sel = 1, jump_sel = 1, jtarget = 0x140, no stall -> pc_sel_IF = 1, pred_pc_IF = 0x140; two cycles later mispredict = 0, flush = 0.
REQ-027 Branch at 0x200, taken_sel = 0, actual taken to 0x300 -> in EXE: mispredict = 1, flush = 1, redirect_pc = 0x300; next cycle both slots invalid.
REQ-028 Branch at 0x400 predicted taken to 0x480, actual not taken -> flush = 1, redirect_pc = 0x404.
REQ-029 Mispredict in EXE with Dstall = 1 for 3 cycles -> flush = 0 for 3 cycles, PEND; flush = 1 with latched redirect_pc in the cycle Dstall drops; next cycle RUN, flush = 0.
REQ-030 pc_IF = 0xFFFFFFFC, not-taken branch -> pred_pc_IF = 0x00000000; mispredict taken to 0x10 -> redirect_pc = 0x10.
REQ-031 With PREDICT_STATS_EN: 5 branches, 2 mispredicted -> branch_cnt = 5, miss_cnt = 2; rst asserted during PEND -> counters 0, no flush.
